prince_sched: RTL and testbench
===============================

# prince_sched

Two-requester scheduler that shares one round-based PRINCE core between independent encrypt/decrypt clients. It arbitrates valid/ready requests round-robin, latches the request operands, and pulses the core start. It counts the core's fixed latency, captures the result, and returns it with the requester ID over a backpressured response port. It sits directly in front of the round-based core, the only block that drives the core's start and operands.

## Interface
Parameters:
- CORE_LAT, 11: cycles from core start pulse (cycle S) until core_dout valid (cycle S+CORE_LAT); must be ≥2
- DW, 64: data block width
- KW, 128: key width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when also valid
- req0_data  in  DW  plaintext/ciphertext
- req0_key  in  KW  key
- req0_dec  in  1  1 = decrypt, 0 = encrypt
- req1_valid / req1_ready / req1_data / req1_key / req1_dec: same as the requester 0 ports, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index of result
- rsp_data  out  DW  result block
- core_st  out  1  one-cycle start pulse to core
- core_din  out  DW  registered operand to core
- core_key  out  KW  registered key to core
- core_dec  out  1  registered direction to core
- core_dout  in  DW  core result

## Operation
- FSM states: IDLE, START, BUSY, RESP.
- IDLE:
  - Grant: if exactly one reqX_valid, grant it. If both, grant the requester not granted last (pointer `last`).
  - reqX_ready = (state==IDLE) & grant[X]. Ready depends combinationally on valid. The ungranted requester sees ready=0.
  - On handshake: latch data/key/dec into core_din/core_key/core_dec, latch id, update `last`, go START.
- START: core_st=1 for exactly this cycle; counter loads 1; go BUSY.
- BUSY:
  - Counter increments each cycle.
  - When counter==CORE_LAT, capture core_dout into rsp_data and go RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id held stable.
  - On rsp_valid & rsp_ready, go IDLE. No request is accepted in this cycle.
- core_din/key/dec hold from acceptance until the next acceptance. The core sees stable operands for the whole operation.
- Counter width is $clog2(CORE_LAT+1); it never wraps within an operation.
- Reset values:
  - state=IDLE, req0_ready=req1_ready=0 (no valid), rsp_valid=0, core_st=0
  - rsp_data=0, rsp_id=0, core_din=0, core_key=0, core_dec=0, counter=0
  - last=1, so requester 0 wins the first tie.
- rst in any state: in-flight operation discarded, no response produced, all registers go to reset values next edge.
- rst overrides a simultaneous handshake; that request is not accepted.
- Requests arriving while not IDLE wait. Requesters must hold valid and operands until ready.

## Timing
- Acceptance edge T (cycle T is IDLE with handshake):
  - core_st=1 in cycle T+1 (= S)
  - core_dout sampled at end of cycle S+CORE_LAT
  - rsp_valid=1 from cycle T+CORE_LAT+2 (13 for default)
- rsp_valid stays high until handshake; response handshake in cycle R makes IDLE at R+1, the earliest next acceptance.
- Max throughput: one operation per CORE_LAT+3 cycles (14 default) with rsp_ready held high.
- Under contention both requesters alternate strictly; no starvation.

## Structure
- Shared package prince_pkg: state enum (IDLE, START, BUSY, RESP), DW/KW defaults, CORE_LAT default.
- Sub-module prince_rr_arb: 2-input round-robin arbiter (valid[1:0], last, en → grant[1:0], new_last). It is reused if requester count grows.
- The scheduler contains the FSM, counter, operand and response registers.

## Test plan
- Single encrypt: reset, req0 data=0x0000000000000000, key=0, dec=0, rsp_ready=1.
  - req0_ready in cycle T; core_st only in T+1; rsp_valid at T+13.
  - rsp_id=0; rsp_data equals core model output (0x818665aa0d02dfda).
- Tie after reset: req0 and req1 valid same cycle → req0 granted first, req1 next. Then both held valid for 4 ops → grants 0,1,0,1, rsp_ids match.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_data/rsp_id stable, no req*_ready. The core sees no extra core_st, and IDLE follows only the cycle after rsp_ready=1.
- Decrypt round-trip: req1 encrypt then req1 decrypt of the result with the same key, dec=1 → second rsp_data equals original plaintext; core_dec=1 held throughout the second op.
- Reset mid-operation: assert rst in BUSY at counter=5 → next cycle state IDLE, rsp_valid=0, core_st=0. No response for the aborted op; a new request afterwards completes with latency 13.
- Random valid toggling with compliant requesters (valid held until ready), 1000 ops → every accepted op yields exactly one response with the correct id. Never more than one outstanding; core_st never pulses outside START.

Source files
------------

// File: rtl/prince_pkg.sv
// Shared types and defaults for the PRINCE core scheduler.
// The state encoding and the two-way round-robin pick live here so other front-ends can reuse them.
package prince_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DW_DEF       = 64;
    localparam int KW_DEF       = 128;
    localparam int CORE_LAT_DEF = 11;

    // A lone requester always wins; on a tie the one not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
        logic [1:0] g;
        g = valid;
        if (valid == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/prince_rr_arb.sv
// Two-input round-robin arbiter; purely combinational, the caller owns the pointer register.
module prince_rr_arb
    import prince_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant,
    output logic       new_last
);

    always_comb begin
        grant    = 2'b00;
        new_last = last;
        if (en) begin
            grant = rr_pick(valid, last);
            if (grant[1]) begin
                new_last = 1'b1;
            end else if (grant[0]) begin
                new_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/prince_sched.sv
// Shares one round-based PRINCE core between two requesters: arbitrate, launch, wait the
// fixed core latency, then hold the result on a backpressured response port.
module prince_sched
    import prince_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEF,
    parameter int DW       = DW_DEF,
    parameter int KW       = KW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic [KW-1:0] req0_key,
    input  logic          req0_dec,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic [KW-1:0] req1_key,
    input  logic          req1_dec,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          core_st,
    output logic [DW-1:0] core_din,
    output logic [KW-1:0] core_key,
    output logic          core_dec,
    input  logic [DW-1:0] core_dout
);

    localparam int            CW      = $clog2(CORE_LAT + 1);
    localparam logic [CW-1:0] LAT_END = CW'(CORE_LAT);

    state_t        state;
    logic          last;
    logic          req_id;
    logic [CW-1:0] cnt;

    logic [1:0]    grant;
    logic          new_last;
    logic          arb_en;
    logic          accept;
    logic [DW-1:0] sel_data;
    logic [KW-1:0] sel_key;
    logic          sel_dec;

    // Reset masks the grant so a request seen during reset is never acknowledged.
    assign arb_en = (state == IDLE) && !rst;

    prince_rr_arb u_arb (
        .valid    ({req1_valid, req0_valid}),
        .last     (last),
        .en       (arb_en),
        .grant    (grant),
        .new_last (new_last)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;

    always_comb begin
        sel_data = req0_data;
        sel_key  = req0_key;
        sel_dec  = req0_dec;
        if (grant[1]) begin
            sel_data = req1_data;
            sel_key  = req1_key;
            sel_dec  = req1_dec;
        end
    end

    // Counter loads 1 in START so it equals the cycles elapsed since the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            req_id    <= 1'b0;
            cnt       <= '0;
            core_st   <= 1'b0;
            core_din  <= '0;
            core_key  <= '0;
            core_dec  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_din <= sel_data;
                        core_key <= sel_key;
                        core_dec <= sel_dec;
                        req_id   <= grant[1];
                        last     <= new_last;
                        core_st  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    core_st <= 1'b0;
                    cnt     <= CW'(1);
                    state   <= BUSY;
                end
                BUSY: begin
                    if (cnt == LAT_END) begin
                        rsp_data  <= core_dout;
                        rsp_id    <= req_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prince_sched.sv
// Bench for prince_sched: behavioural stand-in core, scoreboard of expected responses,
// vector table plus directed contention, backpressure, abort and random sequences.
module tb_prince_sched;

    localparam int L  = 11;
    localparam int DW = 64;
    localparam int KW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    vld;
    logic [1:0]    rdy;
    logic [DW-1:0] dat [2];
    logic [KW-1:0] key [2];
    logic          dec [2];
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_data;
    logic          core_st, core_dec;
    logic [DW-1:0] core_din, core_dout;
    logic [KW-1:0] core_key;

    prince_sched #(.CORE_LAT(L), .DW(DW), .KW(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (vld[0]),
        .req0_ready (rdy[0]),
        .req0_data  (dat[0]),
        .req0_key   (key[0]),
        .req0_dec   (dec[0]),
        .req1_valid (vld[1]),
        .req1_ready (rdy[1]),
        .req1_data  (dat[1]),
        .req1_key   (key[1]),
        .req1_dec   (dec[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .core_st    (core_st),
        .core_din   (core_din),
        .core_key   (core_key),
        .core_dec   (core_dec),
        .core_dout  (core_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic [KW-1:0] key;
        logic          dec;
        int            exp_id;
        logic [DW-1:0] exp_data;
    } vec_t;

    exp_t          sbq[$];
    int            acc_ids[$];
    vec_t          vt[5];
    int            checks = 0, errors = 0;
    int            acc_cnt = 0, rsp_cnt = 0, outstanding = 0;
    int            acc_T = 0, st_T = 0, rsp_T = 0;
    logic          last_id = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic          prev_rv = 1'b0;
    logic          rand_rdy = 1'b0;

    // Invertible stand-in for the cipher: the scheduler only moves its result around.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                            input logic dc);
        logic [DW-1:0] x;
        if (!dc) begin
            x = d ^ k[63:0];
            x = {x[50:0], x[63:51]};
            x = x + k[127:64];
        end else begin
            x = d - k[127:64];
            x = {x[12:0], x[63:13]};
            x = x ^ k[63:0];
        end
        return x;
    endfunction

    function automatic vec_t mkvec(input int s, input logic [DW-1:0] d, input logic [KW-1:0] k,
                                   input logic dc);
        vec_t v;
        v.src      = s;
        v.data     = d;
        v.key      = k;
        v.dec      = dc;
        v.exp_id   = s;
        v.exp_data = model(d, k, dc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_req(input int x, input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic dc, output int t);
        t      = -1;
        dat[x] = d;
        key[x] = k;
        dec[x] = dc;
        vld[x] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy[x]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL req%0d_timeout: not accepted within 400 cycles", x);
        end
        @(posedge clk);
        #1;
        vld[x] = 1'b0;
        dat[x] = {$urandom, $urandom};
        key[x] = {$urandom, $urandom, $urandom, $urandom};
        dec[x] = ~dc;
    endtask

    task automatic wait_rsp(input int n0);
        int i;
        i = 0;
        while (rsp_cnt <= n0 && i < 400) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (rsp_cnt <= n0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %0d responses, expected more than %0d", rsp_cnt, n0);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                outstanding = 0;
                prev_rv     = 1'b0;
            end else begin
                if (rdy == 2'b11) chk("dual_grant", rdy, 2'b01);
                for (int x = 0; x < 2; x++) begin
                    if (vld[x] && rdy[x]) begin
                        e.id   = x[0];
                        e.data = model(dat[x], key[x], dec[x]);
                        sbq.push_back(e);
                        acc_ids.push_back(x);
                        acc_cnt++;
                        acc_T = cyc;
                        outstanding++;
                        chk("outstanding", outstanding, 1);
                    end
                end
                if (core_st) begin
                    st_T = cyc;
                    chk("core_st_time", cyc, acc_T + 1);
                end
                if (rsp_valid && !prev_rv) begin
                    rsp_T = cyc;
                    chk("rsp_latency", cyc - acc_T, L + 2);
                end
                if (rsp_valid && vld != 2'b00) chk("ready_in_resp", rdy, 2'b00);
                if (rsp_valid && rsp_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: id %0d data 0x%0h, expected no response",
                                 rsp_id, rsp_data);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_data", rsp_data, e.data);
                    end
                    last_id   = rsp_id;
                    last_data = rsp_data;
                    rsp_cnt++;
                    outstanding--;
                end
                prev_rv = rsp_valid;
            end
        end
    endtask

    // Result is driven only in cycle S+L; every other cycle carries junk.
    task automatic core_model();
        int            k;
        logic          act;
        logic [DW-1:0] ld;
        logic [KW-1:0] lk;
        logic          ldc;
        k         = 0;
        act       = 1'b0;
        ld        = '0;
        lk        = '0;
        ldc       = 1'b0;
        core_dout = 64'hBAD0_BAD0_BAD0_BAD0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act       = 1'b0;
                core_dout = 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                if (act) begin
                    k++;
                    chk("core_din_stable", core_din, ld);
                    chk("core_key_stable", core_key, lk);
                    chk("core_dec_stable", core_dec, ldc);
                end
                if (core_st) begin
                    chk("core_st_overlap", act, 1'b0);
                    act = 1'b1;
                    k   = 0;
                    ld  = core_din;
                    lk  = core_key;
                    ldc = core_dec;
                end
                if (act && k == L) begin
                    core_dout = model(core_din, core_key, core_dec);
                    act       = 1'b0;
                end else begin
                    core_dout = 64'hBAD0_BAD0_BAD0_BAD0 ^ 64'(cyc);
                end
            end
        end
    endtask

    task automatic rand_ready();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int            t, t2, n, r0, a0, c0, g;
        logic [DW-1:0] p, c, hold_data;
        logic [KW-1:0] k;
        logic          hold_id;

        vld       = 2'b00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dat[i] = '0;
            key[i] = '0;
            dec[i] = 1'b0;
        end
        vt[0] = mkvec(0, 64'h0, 128'h0, 1'b0);
        vt[1] = mkvec(1, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        vt[2] = mkvec(0, 64'h0123_4567_89AB_CDEF, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
        vt[3] = mkvec(1, 64'h8000_0000_0000_0001, 128'h1, 1'b1);
        vt[4] = mkvec(0, 64'hDEAD_BEEF_CAFE_F00D, 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9669_6996, 1'b0);

        fork
            monitor();
            core_model();
            rand_ready();
            begin
                #900000;
                $display("FAIL watchdog: simulation exceeded its cycle budget");
                $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
                $fatal(1);
            end
        join_none

        // reset state, with a request held to show reset masks the handshake
        vld[0] = 1'b1;
        dat[0] = 64'h1111_2222_3333_4444;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_core_st", core_st, 1'b0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_core_din", core_din, 64'h0);
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_core_dec", core_dec, 1'b0);
        vld[0] = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        chk("rst_no_accept", acc_cnt, 0);

        // vector table
        foreach (vt[i]) begin
            n = rsp_cnt;
            do_req(vt[i].src, vt[i].data, vt[i].key, vt[i].dec, t);
            wait_rsp(n);
            chk("vec_id", last_id, vt[i].exp_id[0]);
            chk("vec_data", last_data, vt[i].exp_data);
            if (i == 0) begin
                chk("first_st", st_T, t + 1);
                chk("first_rsp", rsp_T, t + L + 2);
            end
        end

        // tie right after reset: requester 0 first
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_ids.delete();
        n = rsp_cnt;
        fork
            do_req(0, 64'hAAAA_0000_AAAA_0000, 128'h5, 1'b0, t);
            do_req(1, 64'hBBBB_0000_BBBB_0000, 128'h6, 1'b0, t2);
        join
        wait_rsp(n + 1);
        chk("tie_n", acc_ids.size(), 2);
        if (acc_ids.size() == 2) begin
            chk("tie_first", acc_ids[0], 0);
            chk("tie_second", acc_ids[1], 1);
        end

        // sustained contention alternates
        acc_ids.delete();
        n = rsp_cnt;
        fork
            begin
                int ta;
                for (int j = 0; j < 2; j++) do_req(0, {$urandom, $urandom}, 128'h77, 1'b0, ta);
            end
            begin
                int tb;
                for (int j = 0; j < 2; j++) do_req(1, {$urandom, $urandom}, 128'h88, 1'b1, tb);
            end
        join
        wait_rsp(n + 3);
        chk("alt_n", acc_ids.size(), 4);
        if (acc_ids.size() == 4) begin
            for (int j = 0; j < 4; j++) chk("alt_order", acc_ids[j], j % 2);
        end

        // backpressure: held response, waiting requester sees no ready
        rsp_ready = 1'b0;
        n = rsp_cnt;
        p = 64'h0F1E_2D3C_4B5A_6978;
        k = 128'h1357_9BDF_0246_8ACE_1122_3344_5566_7788;
        do_req(0, p, k, 1'b0, t);
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        chk("bp_valid", rsp_valid, 1'b1);
        hold_id   = rsp_id;
        hold_data = rsp_data;
        chk("bp_id", hold_id, 1'b0);
        chk("bp_data", hold_data, model(p, k, 1'b0));
        fork
            begin
                int tc;
                do_req(1, 64'h5555_6666_7777_8888, k, 1'b1, tc);
            end
        join_none
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold_data", rsp_data, hold_data);
            chk("bp_hold_id", rsp_id, hold_id);
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_no_ready", rdy, 2'b00);
            chk("bp_no_st", core_st, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_r_no_ready", rdy[1], 1'b0);
        @(negedge clk);
        chk("bp_r1_ready", rdy[1], 1'b1);
        wait_rsp(n + 1);

        // decrypt round trip on requester 1
        p = 64'hFEED_FACE_0BAD_C0DE;
        k = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        n = rsp_cnt;
        do_req(1, p, k, 1'b0, t);
        wait_rsp(n);
        c = last_data;
        chk("enc_id", last_id, 1'b1);
        n = rsp_cnt;
        do_req(1, c, k, 1'b1, t);
        repeat (12) begin
            @(negedge clk);
            chk("dec_held", core_dec, 1'b1);
        end
        wait_rsp(n);
        chk("roundtrip", last_data, p);

        // reset while BUSY with counter at 5
        n = rsp_cnt;
        do_req(0, 64'h1234_5678_9ABC_DEF0, 128'h42, 1'b0, t);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0  = cyc;
        fork
            begin
                @(negedge clk);
                chk("abort_rsp_valid", rsp_valid, 1'b0);
                chk("abort_core_st", core_st, 1'b0);
                chk("abort_rsp_data", rsp_data, 64'h0);
                chk("abort_core_din", core_din, 64'h0);
            end
            do_req(1, 64'h0BAD_F00D_0BAD_F00D, 128'h99, 1'b0, t2);
        join
        chk("abort_idle_accept", t2, c0);
        wait_rsp(n);
        chk("abort_rsp_lat", rsp_T, t2 + L + 2);
        chk("abort_rsp_id", last_id, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_rsp_count", rsp_cnt, n + 1);

        // random compliant traffic
        a0       = acc_cnt;
        r0       = rsp_cnt;
        rand_rdy = 1'b1;
        fork
            begin
                int td;
                int gd;
                for (int j = 0; j < 500; j++) begin
                    gd = $urandom_range(0, 3);
                    repeat (gd) begin
                        @(posedge clk);
                        #1;
                    end
                    do_req(0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                           1'($urandom_range(0, 1)), td);
                end
            end
            begin
                int te;
                int ge;
                for (int j = 0; j < 500; j++) begin
                    ge = $urandom_range(0, 3);
                    repeat (ge) begin
                        @(posedge clk);
                        #1;
                    end
                    do_req(1, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                           1'($urandom_range(0, 1)), te);
                end
            end
        join
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        g = 0;
        while ((rsp_cnt - r0) < (acc_cnt - a0) && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("rand_accepts", acc_cnt - a0, 1000);
        chk("rand_responses", rsp_cnt - r0, 1000);
        chk("rand_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
